// File: rtl/adc_spi_expander.sv
// adc_spi_expander: drives a 12-bit serial ADC frame (cs_n/sclk/sdata) and
// converts each offset-binary sample into a signed N-bit fixed-point word.
// Optional build macro: ADC_MIDSCALE_FILL_EN
//   defined   -> fill bits are a single 1 at bit N-13 (half-LSB centring)
//   undefined -> all N-12 fill bits are 0
module adc_spi_expander #(
    parameter int N   = 16,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sdata,
    output logic         cs_n,
    output logic         sclk,
    output logic         busy,
    output logic [N-1:0] Dato_Out,
    output logic         valid
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_DONE,
        S_QUIET
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  div_q,   div_d;
    logic [4:0]     bits_q,  bits_d;
    logic [15:0]    shreg_q, shreg_d;
    logic           sclk_q,  sclk_d;
    logic           cs_n_q,  cs_n_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   dato_q,  dato_d;

    logic           div_tc;
    logic [N-1:0]   conv;

    assign div_tc = (div_q == CW'(DIV - 1));

    // Offset-binary to two's complement: flip the sign bit, left-justify, add fill.
    always_comb begin
        conv         = '0;
        conv[N-1]    = ~shreg_q[11];
        conv[N-2 -: 11] = shreg_q[10:0];
`ifdef ADC_MIDSCALE_FILL_EN
        conv[N-13]   = 1'b1;
`endif
    end

    // Frame sequencer: next-state and registered-output decisions.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        valid_d = 1'b0;
        dato_d  = dato_q;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                div_d  = '0;
                if (start) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    bits_d  = '0;
                end
            end

            S_SETUP: begin
                if (div_tc) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (div_tc) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // A low-to-high toggle is the ADC sampling point.
                    if (!sclk_q) begin
                        shreg_d = {shreg_q[14:0], sdata};
                        bits_d  = bits_q + 5'd1;
                        if (bits_q == 5'd15) begin
                            state_d = S_DONE;
                            cs_n_d  = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_DONE: begin
                cs_n_d  = 1'b1;
                dato_d  = conv;
                valid_d = 1'b1;
                div_d   = '0;
                state_d = S_QUIET;
            end

            S_QUIET: begin
                cs_n_d = 1'b1;
                if (div_tc) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                div_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame without a valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bits_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            valid_q <= 1'b0;
            dato_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            valid_q <= valid_d;
            dato_q  <= dato_d;
        end
    end

    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign busy     = (state_q != S_IDLE);
    assign valid    = valid_q;
    assign Dato_Out = dato_q;

endmodule

// File: tb/tb_adc_spi_expander.sv
// Bench for adc_spi_expander: a frame-timeline reference model (expected pin
// levels as a function of cycles since the accepted start) plus an ADC model
// that presents each code MSB first, checked every cycle on the falling edge.
module tb_adc_spi_expander;

    localparam int N   = 16;
    localparam int DIV = 4;
`ifdef ADC_MIDSCALE_FILL_EN
    localparam logic [N-1:0] FILL = 16'h0008;
`else
    localparam logic [N-1:0] FILL = 16'h0000;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         sdata = 1'b0;
    logic         cs_n, sclk, busy, valid;
    logic [N-1:0] Dato_Out;

    adc_spi_expander #(.N(N), .DIV(DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sdata    (sdata),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .busy     (busy),
        .Dato_Out (Dato_Out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           t0 = 0;
    int           vcount = 0;
    int           vcyc = 0;
    int           rises = 0;
    int           bcount = 0;
    bit           active = 1'b0;
    logic         prev_sclk = 1'b1;
    logic [15:0]  code = '0;
    logic [15:0]  cur_code = '0;
    logic [N-1:0] exp_dato = '0;
    logic         nxt_start = 1'b0;
    logic         nxt_reset = 1'b1;

    // Signed value of the ADC code scaled to N bits: (code - midscale) * 2^(N-12) + fill.
    function automatic logic [N-1:0] model_conv(input logic [15:0] w);
        int v;
        v = (int'(w[11:0]) - 2048) * (1 << (N - 12)) + int'(FILL);
        return v[N-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        int   o;
        int   k;
        logic run;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (active && (cyc - 1 - t0) > 33 * DIV) active = 1'b0;
            if (!active && start) begin
                active = 1'b1;
                t0     = cyc;
                code   = cur_code;
                rises  = 0;
            end
            if (active && (cyc - t0) == 32 * DIV + 1) exp_dato = model_conv(code);
        end
        @(negedge clk);
        o   = cyc - t0;
        run = active && (o < 32 * DIV);
        chk("busy",  32'(busy),  32'(active && o <= 33 * DIV));
        chk("cs_n",  32'(cs_n),  32'(!run));
        chk("sclk",  32'(sclk),  run ? 32'(((o / DIV) % 2) == 0) : 32'd1);
        chk("valid", 32'(valid), 32'(active && o == 32 * DIV + 1));
        chk("dato",  32'(Dato_Out), 32'(exp_dato));
        if (!prev_sclk && sclk) rises++;
        prev_sclk = sclk;
        if (valid) begin
            vcount++;
            vcyc = o;
        end
        if (busy) bcount++;

        start     = nxt_start;
        nxt_start = 1'b0;
        if (nxt_reset && !reset) begin
            reset = 1'b1;
            #1;
            active   = 1'b0;
            exp_dato = '0;
            chk("rst_cs_n",  32'(cs_n),  32'd1);
            chk("rst_sclk",  32'(sclk),  32'd1);
            chk("rst_busy",  32'(busy),  32'd0);
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_dato",  32'(Dato_Out), 32'd0);
        end else begin
            reset = nxt_reset;
        end
        if (active) begin
            k = (o + 2 * DIV) / (2 * DIV);
            sdata = (k >= 1 && k <= 16) ? code[16 - k] : 1'($urandom);
        end else begin
            sdata = 1'($urandom);
        end
    endtask

    task automatic frame(input logic [15:0] w, input logic [N-1:0] lit);
        cur_code  = w;
        vcount    = 0;
        nxt_start = 1'b1;
        step();
        repeat (33 * DIV + 3) step();
        chk("frame_valid_count", 32'(vcount), 32'd1);
        chk("frame_latency",     32'(vcyc),   32'd129);
        chk("frame_dato",        32'(Dato_Out), 32'(lit));
        chk("frame_sclk_rises",  32'(rises),  32'd16);
    endtask

    initial begin
        repeat (3) step();
        nxt_reset = 1'b0;
        step();
        chk("idle_cs_n", 32'(cs_n), 32'd1);
        chk("idle_sclk", 32'(sclk), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dato", 32'(Dato_Out), 32'd0);

        // Midscale, full negative, full positive with garbage leading nibble.
        frame(16'h0800, 16'h0000 | FILL);
        frame(16'h0000, 16'h8000 | FILL);
        frame(16'hFFFF, 16'h7FF0 | FILL);
        repeat (5) step();

        // Second start 50 cycles into a frame must be dropped.
        cur_code  = 16'h0ABC;
        vcount    = 0;
        bcount    = 0;
        nxt_start = 1'b1;
        step();
        repeat (50) step();
        nxt_start = 1'b1;
        repeat (100) step();
        chk("ignored_start_valids", 32'(vcount), 32'd1);
        chk("busy_span",            32'(bcount), 32'd133);
        chk("ignored_start_dato",   32'(Dato_Out), 32'(16'hABC0 ^ 16'h8000 | FILL));

        // Reset 40 cycles into a frame: no valid, then a clean frame.
        cur_code  = 16'h0123;
        vcount    = 0;
        nxt_start = 1'b1;
        step();
        repeat (40) step();
        nxt_reset = 1'b1;
        step();
        repeat (3) step();
        nxt_reset = 1'b0;
        repeat (200) step();
        chk("aborted_valids", 32'(vcount), 32'd0);
        frame(16'h0F00, 16'hF000 ^ 16'h8000 | FILL);

        // Random starts, codes and occasional mid-frame resets.
        for (int i = 0; i < 6000; i++) begin
            cur_code  = 16'($urandom);
            nxt_start = ($urandom_range(0, 29) == 0);
            nxt_reset = ($urandom_range(0, 1999) == 0) || (reset && $urandom_range(0, 1) == 0);
            step();
        end
        nxt_reset = 1'b0;
        repeat (2 * 33 * DIV) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
